// File: rtl/diff_tx_pkg.sv
// Shared types and constants for the differential serial transmitter.
package diff_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  function automatic int unsigned frame_bits(input int unsigned data_w, input bit parity_en);
    return data_w + 32'd2 + (parity_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/diff_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_tick at terminal count.
module diff_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick = (cnt_q == CNT_LAST);
    if (clear || bit_tick) cnt_d = '0;
    else                   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/diff_serial_tx.sv
// UART-style frame serializer driving a true/complement pair from one registered line bit.
// Optional even parity bit after the data when DIFF_TX_PARITY_EN is defined.
module diff_serial_tx
  import diff_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_p,
  output logic              tx_n,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              line_q, line_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              timer_clear;
  logic              bit_tick;
`ifdef DIFF_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  diff_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    line_d      = line_q;
    timer_clear = 1'b0;
`ifdef DIFF_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        line_d = LINE_IDLE;
        if (tx_valid) begin
          shift_d     = tx_data;
          idx_d       = '0;
          state_d     = START;
          line_d      = LINE_START;
          timer_clear = 1'b1;
`ifdef DIFF_TX_PARITY_EN
          parity_d    = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        // line is registered, so the next bit is loaded from shift_q[1] ahead of the shift
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
`ifdef DIFF_TX_PARITY_EN
            state_d = PARITY;
            line_d  = parity_q;
`else
            state_d = STOP;
            line_d  = LINE_IDLE;
`endif
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            line_d = shift_q[1];
          end
        end
      end
`ifdef DIFF_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          line_d  = LINE_IDLE;
        end
      end
`endif
      STOP: begin
        line_d = LINE_IDLE;
        if (bit_tick) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        line_d  = LINE_IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      line_q   <= LINE_IDLE;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef DIFF_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
`ifdef DIFF_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_p     = line_q;
  assign tx_n     = ~line_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;

endmodule
